mdio_responder: RTL and testbench

Clause-22 MDIO management responder (PHY side) with a 32 x 16 register file. It decodes serial management frames arriving on mdc/mdio and services reads by driving mdio. It reports every accepted write to local logic through a one-cycle strobe. It serves as the bench/loopback target for the SoC MDIO master and as a management port for FPGA-side PHY-like cores.

---
 rtl/mdio_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY side): decodes mdc/mdio frames in the clk domain,
// serves a 32 x 16 register file with three read-only ID/status registers.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR   = 5'd1,
  parameter logic [15:0] STATUS_VAL = 16'h782D,
  parameter logic [15:0] PHY_ID1    = 16'h0022,
  parameter logic [15:0] PHY_ID2    = 16'h1622
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        mdc,
  inout  wire         mdio,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        frame_err,
  output logic [2:0]  dbg_state,
  output logic        dbg_oe
);
  typedef enum logic [2:0] {
    S_PRE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA
  } state_t;

  state_t      state_q, state_d;
  logic        mdc_s1_q, mdc_s2_q, mdc_h_q, mdio_s1_q, mdio_s2_q;
  logic        mdc_rise, mdc_fall, din;
  logic [5:0]  ones_q, ones_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] sh_q, sh_d;
  logic [4:0]  regad_q, regad_d;
  logic        read_q, read_d, match_q, match_d;
  logic        oe_q, oe_d, out_q, out_d;
  logic        busy_q, busy_d, ferr_q, ferr_d;
  logic        wr_valid_q, wr_valid_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] regs_q [32];
  logic [4:0]  addr_in;
  logic [15:0] rd_word, wr_word;
  logic        commit, err;

  assign mdio = oe_q ? out_q : 1'bz;

  // Synchronisers idle high so reset release never looks like an mdc rise.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mdc_s1_q  <= 1'b1;
      mdc_s2_q  <= 1'b1;
      mdc_h_q   <= 1'b1;
      mdio_s1_q <= 1'b1;
      mdio_s2_q <= 1'b1;
    end else begin
      mdc_s1_q  <= mdc;
      mdc_s2_q  <= mdc_s1_q;
      mdc_h_q   <= mdc_s2_q;
      mdio_s1_q <= mdio;
      mdio_s2_q <= mdio_s1_q;
    end
  end

  assign mdc_rise = mdc_s2_q & ~mdc_h_q;
  assign mdc_fall = ~mdc_s2_q & mdc_h_q;
  assign din      = mdio_s2_q;
  assign addr_in  = {sh_q[3:0], din};
  assign wr_word  = {sh_q[14:0], din};

  always_comb begin
    rd_word = regs_q[addr_in];
    case (addr_in)
      5'd1:    rd_word = STATUS_VAL;
      5'd2:    rd_word = PHY_ID1;
      5'd3:    rd_word = PHY_ID2;
      default: rd_word = regs_q[addr_in];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    regad_d    = regad_q;
    read_d     = read_q;
    match_d    = match_q;
    oe_d       = oe_q;
    out_d      = out_q;
    busy_d     = busy_q;
    ferr_d     = 1'b0;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    commit     = 1'b0;
    err        = 1'b0;
    if (mdc_fall) begin
      case (state_q)
        S_PRE: begin
          if (din) begin
            if (ones_q != 6'd32) ones_d = ones_q + 6'd1;
          end else if (ones_q == 6'd32) begin
            busy_d  = 1'b1;
            ones_d  = '0;
            state_d = S_ST1;
          end else begin
            ones_d = '0;
          end
        end
        S_ST1: begin
          if (din) begin
            bit_d   = '0;
            state_d = S_OP;
          end else err = 1'b1;
        end
        S_OP: begin
          sh_d  = wr_word;
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd1) begin
            bit_d   = '0;
            state_d = S_PHYAD;
            case ({sh_q[0], din})
              2'b10:   read_d = 1'b1;
              2'b01:   read_d = 1'b0;
              default: err = 1'b1;
            endcase
          end
        end
        S_PHYAD: begin
          sh_d  = wr_word;
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd4) begin
            match_d = (addr_in == PHY_ADDR);
            bit_d   = '0;
            state_d = S_REGAD;
          end
        end
        S_REGAD: begin
          sh_d  = wr_word;
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd4) begin
            regad_d = addr_in;
            bit_d   = '0;
            state_d = S_TA;
            if (read_q && match_q) sh_d = rd_word;
          end
        end
        S_TA: begin
          if (!read_q) begin
            if (bit_q == 5'd0) begin
              if (din) bit_d = 5'd1;
              else err = 1'b1;
            end else if (din) begin
              err = 1'b1;
            end else begin
              bit_d   = '0;
              state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          sh_d  = wr_word;
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd15) begin
            commit     = match_q;
            wr_valid_d = match_q;
            if (match_q) begin
              wr_addr_d = regad_q;
              wr_data_d = wr_word;
            end
            bit_d   = '0;
            busy_d  = 1'b0;
            state_d = S_PRE;
          end
        end
        default: ;
      endcase
      if (err) begin
        ferr_d  = 1'b1;
        busy_d  = 1'b0;
        ones_d  = '0;
        bit_d   = '0;
        state_d = S_PRE;
      end
    end else if (mdc_rise) begin
      // Read turnaround: first rising edge stays Z, second drives the TA 0.
      if (state_q == S_TA && read_q) begin
        if (bit_q == 5'd0) begin
          bit_d = 5'd1;
        end else begin
          oe_d    = match_q;
          out_d   = 1'b0;
          bit_d   = '0;
          state_d = S_RDATA;
        end
      end else if (state_q == S_RDATA) begin
        if (bit_q != 5'd16) begin
          out_d = sh_q[15];
          sh_d  = {sh_q[14:0], 1'b0};
          bit_d = bit_q + 5'd1;
        end else begin
          oe_d    = 1'b0;
          bit_d   = '0;
          busy_d  = 1'b0;
          state_d = S_PRE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_PRE;
      ones_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      regad_q    <= '0;
      read_q     <= 1'b0;
      match_q    <= 1'b0;
      oe_q       <= 1'b0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      regad_q    <= regad_d;
      read_q     <= read_d;
      match_q    <= match_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Soft reset (reg 0 bit 15) wipes the whole file, reg 0 included.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (commit) begin
      if (regad_q == 5'd0 && wr_word[15]) begin
        for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (regad_q != 5'd1 && regad_q != 5'd2 && regad_q != 5'd3) begin
        regs_q[regad_q] <= wr_word;
      end
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;
  assign dbg_state = state_q;
  assign dbg_oe    = oe_q;
endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: bit-banged MDIO master plus activity monitor.
module tb_mdio_responder;
  localparam int HALF = 80;
  localparam logic [2:0] ST_PRE = 3'd0;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        m_oe = 1'b1;
  logic        m_out = 1'b1;
  wire         mdio;
  logic        wr_valid, busy, frame_err, dbg_oe;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int wr_cycles = 0, oe_cycles = 0, ferr_cycles = 0, busy_cycles = 0;
  logic [4:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  assign mdio = m_oe ? m_out : 1'bz;

  always #5 clk = ~clk;

  mdio_responder dut (
    .clk(clk), .arst_n(arst_n), .mdc(mdc), .mdio(mdio),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_err(frame_err), .dbg_state(dbg_state), .dbg_oe(dbg_oe)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cycles++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (dbg_oe) oe_cycles++;
    if (frame_err) ferr_cycles++;
    if (busy) busy_cycles++;
  end

  // ---------------- master driver tasks ----------------
  task automatic drive_bit(input logic b);
    mdc = 1'b1; m_oe = 1'b1; m_out = b; #(HALF);
    mdc = 1'b0; #(HALF);
  endtask

  task automatic drive_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] regad);
    for (int i = 0; i < pre; i++) drive_bit(1'b1);
    drive_bits(16'b01, 2);
    drive_bits({14'd0, op}, 2);
    drive_bits({11'd0, phy}, 5);
    drive_bits({11'd0, regad}, 5);
  endtask

  task automatic write_frame(input logic [4:0] phy, input logic [4:0] regad, input logic [15:0] data);
    send_header(32, 2'b01, phy, regad);
    drive_bits(16'b10, 2);
    drive_bits(data, 16);
  endtask

  task automatic read_cycle(output logic oe_s, output logic d_s);
    mdc = 1'b1; m_oe = 1'b0; #(HALF - 10);
    oe_s = dbg_oe; d_s = mdio; #10;
    mdc = 1'b0; #(HALF);
  endtask

  task automatic read_frame(input logic [4:0] phy, input logic [4:0] regad, output logic [15:0] data,
                            output logic ta1_oe, output logic ta2_oe, output logic ta2_d,
                            output logic end_oe);
    logic o, d;
    send_header(32, 2'b10, phy, regad);
    read_cycle(ta1_oe, d);
    read_cycle(ta2_oe, ta2_d);
    for (int i = 15; i >= 0; i--) begin
      read_cycle(o, d);
      data[i] = d;
    end
    mdc = 1'b1; #(HALF - 10);
    end_oe = dbg_oe; m_oe = 1'b1; m_out = 1'b1; #10;
    mdc = 1'b0; #(HALF);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #20;
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wr_valid: got %b want 0", wr_valid); end
    n_checks++; if (wr_addr !== 5'd0) begin n_fail++; $display("FAIL rst_wr_addr: got %h want 00", wr_addr); end
    n_checks++; if (wr_data !== 16'h0000) begin n_fail++; $display("FAIL rst_wr_data: got %h want 0000", wr_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    n_checks++; if (dbg_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", dbg_oe); end
    n_checks++; if (dbg_state !== ST_PRE) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    #20 arst_n = 1'b1;
    #100;
  endtask

  task automatic test_write_read;
    logic [15:0] d; logic t1, t2, t2d, eo; int w0;
    w0 = wr_cycles;
    write_frame(5'd1, 5'd4, 16'hA5C3);
    n_checks++; if (wr_cycles - w0 !== 1) begin n_fail++; $display("FAIL wr_pulse_len: got %0d cycles want 1", wr_cycles - w0); end
    n_checks++; if (last_addr !== 5'h04) begin n_fail++; $display("FAIL wr_addr: got %h want 04", last_addr); end
    n_checks++; if (last_data !== 16'hA5C3) begin n_fail++; $display("FAIL wr_data: got %h want a5c3", last_data); end
    read_frame(5'd1, 5'd4, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'hA5C3) begin n_fail++; $display("FAIL rd_reg4: got %h want a5c3", d); end
    n_checks++; if (t1 !== 1'b0) begin n_fail++; $display("FAIL rd_ta1_z: got oe %b want 0", t1); end
    n_checks++; if (t2 !== 1'b1 || t2d !== 1'b0) begin n_fail++; $display("FAIL rd_ta2: got oe %b d %b want oe 1 d 0", t2, t2d); end
    n_checks++; if (eo !== 1'b0) begin n_fail++; $display("FAIL rd_release_r19: got oe %b want 0", eo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_readonly;
    logic [15:0] d; logic t1, t2, t2d, eo; int w0;
    read_frame(5'd1, 5'd2, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'h0022) begin n_fail++; $display("FAIL rd_id1: got %h want 0022", d); end
    read_frame(5'd1, 5'd1, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'h782D) begin n_fail++; $display("FAIL rd_status: got %h want 782d", d); end
    read_frame(5'd1, 5'd3, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'h1622) begin n_fail++; $display("FAIL rd_id2: got %h want 1622", d); end
    w0 = wr_cycles;
    write_frame(5'd1, 5'd2, 16'h0000);
    n_checks++; if (wr_cycles - w0 !== 1) begin n_fail++; $display("FAIL ro_wr_pulse: got %0d cycles want 1", wr_cycles - w0); end
    n_checks++; if (last_addr !== 5'h02 || last_data !== 16'h0000) begin n_fail++; $display("FAIL ro_wr_fields: got %h/%h want 02/0000", last_addr, last_data); end
    read_frame(5'd1, 5'd2, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'h0022) begin n_fail++; $display("FAIL ro_id1_kept: got %h want 0022", d); end
  endtask

  task automatic test_mismatch;
    logic [15:0] d; logic t1, t2, t2d, eo; int w0, o0, b0;
    w0 = wr_cycles; o0 = oe_cycles; b0 = busy_cycles;
    write_frame(5'd7, 5'd4, 16'hFFFF);
    n_checks++; if (wr_cycles - w0 !== 0) begin n_fail++; $display("FAIL mm_no_wr: got %0d want 0", wr_cycles - w0); end
    n_checks++; if (oe_cycles - o0 !== 0) begin n_fail++; $display("FAIL mm_no_oe: got %0d want 0", oe_cycles - o0); end
    n_checks++; if (busy_cycles - b0 <= 0) begin n_fail++; $display("FAIL mm_tracked: got busy cycles %0d want >0", busy_cycles - b0); end
    n_checks++; if (dbg_state !== ST_PRE) begin n_fail++; $display("FAIL mm_state_end: got %0d want 0", dbg_state); end
    read_frame(5'd1, 5'd4, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'hA5C3) begin n_fail++; $display("FAIL mm_reg4_kept: got %h want a5c3", d); end
  endtask

  task automatic test_preamble;
    logic [15:0] d; logic t1, t2, t2d, eo; int o0, b0, f0;
    o0 = oe_cycles; b0 = busy_cycles; f0 = ferr_cycles;
    drive_bit(1'b0);
    for (int i = 0; i < 31; i++) drive_bit(1'b1);
    drive_bits(16'b0110, 4);
    drive_bits(16'b00001, 5);
    drive_bits(16'b00010, 5);
    for (int i = 0; i < 18; i++) drive_bit(1'b1);
    n_checks++; if (oe_cycles - o0 !== 0) begin n_fail++; $display("FAIL pre31_no_oe: got %0d want 0", oe_cycles - o0); end
    n_checks++; if (busy_cycles - b0 !== 0) begin n_fail++; $display("FAIL pre31_no_busy: got %0d want 0", busy_cycles - b0); end
    n_checks++; if (dbg_state !== ST_PRE) begin n_fail++; $display("FAIL pre31_state: got %0d want 0", dbg_state); end
    n_checks++; if (ferr_cycles - f0 !== 0) begin n_fail++; $display("FAIL pre31_no_err: got %0d want 0", ferr_cycles - f0); end
    read_frame(5'd1, 5'd4, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'hA5C3 || t2 !== 1'b1) begin n_fail++; $display("FAIL pre32_read: got %h oe %b want a5c3 oe 1", d, t2); end
    f0 = ferr_cycles; b0 = busy_cycles;
    for (int i = 0; i < 32; i++) drive_bit(1'b1);
    drive_bits(16'b0111, 4);
    n_checks++; if (ferr_cycles - f0 !== 1) begin n_fail++; $display("FAIL op11_err_pulse: got %0d cycles want 1", ferr_cycles - f0); end
    n_checks++; if (busy_cycles - b0 <= 0) begin n_fail++; $display("FAIL op11_busy_seen: got %0d want >0", busy_cycles - b0); end
    n_checks++; if (busy !== 1'b0 || dbg_state !== ST_PRE) begin n_fail++; $display("FAIL op11_abort: got busy %b state %0d want 0/0", busy, dbg_state); end
  endtask

  task automatic test_soft_reset;
    logic [15:0] d; logic t1, t2, t2d, eo;
    write_frame(5'd1, 5'd4, 16'h1234);
    read_frame(5'd1, 5'd4, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'h1234) begin n_fail++; $display("FAIL sr_pre_reg4: got %h want 1234", d); end
    write_frame(5'd1, 5'd0, 16'h8000);
    n_checks++; if (last_addr !== 5'h00 || last_data !== 16'h8000) begin n_fail++; $display("FAIL sr_wr_fields: got %h/%h want 00/8000", last_addr, last_data); end
    read_frame(5'd1, 5'd4, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL sr_reg4: got %h want 0000", d); end
    read_frame(5'd1, 5'd0, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL sr_reg0: got %h want 0000", d); end
  endtask

  task automatic test_async_reset;
    logic [15:0] d; logic t1, t2, t2d, eo, o, b; int w0;
    write_frame(5'd1, 5'd4, 16'hBEEF);
    send_header(32, 2'b10, 5'd1, 5'd4);
    for (int i = 0; i < 9; i++) read_cycle(o, b);
    mdc = 1'b1; m_oe = 1'b0; #60;
    n_checks++; if (dbg_oe !== 1'b1 || mdio !== 1'b0) begin n_fail++; $display("FAIL ar_d8_drive: got oe %b d %b want 1/0", dbg_oe, mdio); end
    arst_n = 1'b0; #1;
    n_checks++; if (dbg_oe !== 1'b0) begin n_fail++; $display("FAIL ar_oe_drop: got %b want 0", dbg_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy_drop: got %b want 0", busy); end
    #9; mdc = 1'b0; m_oe = 1'b1; m_out = 1'b1;
    #200; arst_n = 1'b1; #100;
    w0 = wr_cycles;
    write_frame(5'd1, 5'd6, 16'h5A5A);
    n_checks++; if (wr_cycles - w0 !== 1) begin n_fail++; $display("FAIL ar_wr_pulse: got %0d want 1", wr_cycles - w0); end
    n_checks++; if (last_addr !== 5'h06 || last_data !== 16'h5A5A) begin n_fail++; $display("FAIL ar_wr_fields: got %h/%h want 06/5a5a", last_addr, last_data); end
    read_frame(5'd1, 5'd6, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'h5A5A) begin n_fail++; $display("FAIL ar_rd_reg6: got %h want 5a5a", d); end
    read_frame(5'd1, 5'd4, d, t1, t2, t2d, eo);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL ar_reg4_cleared: got %h want 0000", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_readonly();
    test_mismatch();
    test_preamble();
    test_soft_reset();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
